// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the bus_query memory bus: grants M0 (I-cache) or M1 (D-cache)
// one whole transaction at a time, forwards only the active phase, and flags burst beat-count errors.
package mem_bus_pkg;
    typedef struct packed {
        logic        arvalid;
        logic [31:0] araddr;
        logic [3:0]  rlen;
        logic        rready;
        logic        awvalid;
        logic [31:0] waddr;
        logic [3:0]  wlen;
        logic        wvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        bready;
    } bus_query_req_t;

    typedef struct packed {
        logic        rready;   // read-address ready
        logic        rvalid;
        logic [31:0] rdata;
        logic        rlast;
        logic        awready;
        logic        wready;
        logic        bvalid;
    } bus_query_resp_t;
endpackage

module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter int MAX_BURST  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  bus_query_req_t  m0_req,
    output bus_query_resp_t m0_resp,
    input  bus_query_req_t  m1_req,
    output bus_query_resp_t m1_resp,
    output bus_query_req_t  s_req,
    input  bus_query_resp_t s_resp,
    output logic [1:0]      grant,
    output logic            proto_err
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP} state_t;

    state_t          state_reg, state_next;
    logic            owner_reg, owner_next;
    logic            last_owner_reg, last_owner_next;
    logic [4:0]      cnt_reg, cnt_next;
    logic [4:0]      len_reg, len_next;
    logic            proto_err_reg, proto_err_next;
    logic [4:0]      cnt_plus;
    logic            done;
    bus_query_req_t  m0_eff;
    bus_query_req_t  own_req;
    bus_query_resp_t own_resp;
    bus_query_resp_t resp_arr [2];

    function automatic logic [4:0] burst_len(input logic [3:0] field);
        return (field == 4'd0) ? 5'(MAX_BURST) : {1'b0, field};
    endfunction

    assign cnt_plus = cnt_reg + 5'd1;

    // The I-cache never writes: its write-side fields are forced to zero.
    always_comb begin
        m0_eff         = m0_req;
        m0_eff.awvalid = 1'b0;
        m0_eff.waddr   = '0;
        m0_eff.wlen    = '0;
        m0_eff.wvalid  = 1'b0;
        m0_eff.wdata   = '0;
        m0_eff.wstrb   = '0;
        m0_eff.wlast   = 1'b0;
        m0_eff.bready  = 1'b0;
        own_req        = owner_reg ? m1_req : m0_eff;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            last_owner_reg <= 1'b1;
            cnt_reg        <= '0;
            len_reg        <= '0;
            proto_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            cnt_reg        <= cnt_next;
            len_reg        <= len_next;
            proto_err_reg  <= proto_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        cnt_next        = cnt_reg;
        len_next        = len_reg;
        proto_err_next  = proto_err_reg;
        done            = 1'b0;
        s_req           = '0;
        own_resp        = '0;

        case (state_reg)
            IDLE: begin
                if (m0_eff.arvalid || m1_req.arvalid || m1_req.awvalid) begin
                    // On a tie, round-robin favours whoever did not own the bus last.
                    if (m0_eff.arvalid && (m1_req.arvalid || m1_req.awvalid))
                        owner_next = (FIXED_PRIO != 0) ? 1'b1 : ~last_owner_reg;
                    else
                        owner_next = ~m0_eff.arvalid;
                    state_next = (owner_next && m1_req.awvalid) ? WR_ADDR : RD_ADDR;
                end
            end
            RD_ADDR: begin
                s_req.arvalid   = own_req.arvalid;
                s_req.araddr    = own_req.araddr;
                s_req.rlen      = own_req.rlen;
                own_resp.rready = s_resp.rready;
                if (own_req.arvalid && s_resp.rready) begin
                    len_next   = burst_len(own_req.rlen);
                    cnt_next   = '0;
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                s_req.rready    = own_req.rready;
                own_resp.rvalid = s_resp.rvalid;
                own_resp.rdata  = s_resp.rdata;
                own_resp.rlast  = s_resp.rlast;
                if (s_resp.rvalid && own_req.rready) begin
                    cnt_next = cnt_plus;
                    // Burst ends on rlast or on the expected final beat, whichever comes first.
                    if (s_resp.rlast || cnt_plus == len_reg) begin
                        if (!(s_resp.rlast && cnt_plus == len_reg))
                            proto_err_next = 1'b1;
                        done = 1'b1;
                    end
                end
            end
            WR_ADDR: begin
                s_req.awvalid    = own_req.awvalid;
                s_req.waddr      = own_req.waddr;
                s_req.wlen       = own_req.wlen;
                own_resp.awready = s_resp.awready;
                if (own_req.awvalid && s_resp.awready) begin
                    len_next   = burst_len(own_req.wlen);
                    cnt_next   = '0;
                    state_next = WR_DATA;
                end
            end
            WR_DATA: begin
                s_req.wvalid    = own_req.wvalid;
                s_req.wdata     = own_req.wdata;
                s_req.wstrb     = own_req.wstrb;
                s_req.wlast     = own_req.wlast;
                own_resp.wready = s_resp.wready;
                if (own_req.wvalid && s_resp.wready) begin
                    cnt_next = cnt_plus;
                    if (own_req.wlast) begin
                        if (cnt_plus != len_reg)
                            proto_err_next = 1'b1;
                        state_next = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                s_req.bready    = own_req.bready;
                own_resp.bvalid = s_resp.bvalid;
                if (s_resp.bvalid && own_req.bready)
                    done = 1'b1;
            end
            default: state_next = IDLE;
        endcase

        if (done) begin
            state_next      = IDLE;
            last_owner_next = owner_reg;
            cnt_next        = '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            assign resp_arr[gi] = (state_reg != IDLE && owner_reg == 1'(gi)) ? own_resp : '0;
        end
    endgenerate

    assign m0_resp   = resp_arr[0];
    assign m1_resp   = resp_arr[1];
    assign grant     = (state_reg == IDLE) ? 2'b00 : (owner_reg ? 2'b10 : 2'b01);
    assign proto_err = proto_err_reg;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a cycle table for reads/arbitration, then hand-written
// sequences for priority policy, write bursts, beat-count errors and mid-burst reset.
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    bus_query_req_t  m0_req, m1_req, fp_m1_req;
    bus_query_resp_t s_resp;
    bus_query_resp_t m0_resp, m1_resp, fp_m0_resp, fp_m1_resp;
    bus_query_req_t  s_req, fp_s_req;
    logic [1:0]      grant, fp_grant;
    logic            proto_err, fp_proto_err;

    int n_vec = 0;
    int n_err = 0;

    mem_bus_arbiter #(.FIXED_PRIO(0), .MAX_BURST(16)) dut (
        .clk(clk), .rst(rst), .m0_req(m0_req), .m0_resp(m0_resp), .m1_req(m1_req),
        .m1_resp(m1_resp), .s_req(s_req), .s_resp(s_resp), .grant(grant), .proto_err(proto_err)
    );

    mem_bus_arbiter #(.FIXED_PRIO(1), .MAX_BURST(16)) dut_fp (
        .clk(clk), .rst(rst), .m0_req(m0_req), .m0_resp(fp_m0_resp), .m1_req(fp_m1_req),
        .m1_resp(fp_m1_resp), .s_req(fp_s_req), .s_resp(s_resp), .grant(fp_grant),
        .proto_err(fp_proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        m0_ar, m1_ar, s_arrdy, s_rvalid, s_rlast;
        bit [1:0]  grant;
        bit        s_arvalid;
        bit [31:0] s_araddr;
        bit        s_rready, m0_rvalid, m1_rvalid;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(input bit m0a, m1a, ardy, rv, rl, input bit [1:0] g,
                                input bit sav, input bit [31:0] sad, input bit srr, r0, r1);
        vec_t v;
        v.m0_ar = m0a; v.m1_ar = m1a; v.s_arrdy = ardy; v.s_rvalid = rv; v.s_rlast = rl;
        v.grant = g; v.s_arvalid = sav; v.s_araddr = sad; v.s_rready = srr;
        v.m0_rvalid = r0; v.m1_rvalid = r1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // M0 read through the main DUT; slave returns beats back-to-back, rlast on beat rlast_beat.
    task automatic read_txn(input logic [3:0] rlen, input int rlast_beat, output int beats);
        bit ar_done = 1'b0, seen = 1'b0, fin = 1'b0;
        beats = 0;
        m0_req.araddr = 32'h8000_0100; m0_req.rlen = rlen; m0_req.rready = 1'b1;
        s_resp.rready = 1'b1;
        for (int c = 0; c < 80 && !fin; c++) begin
            m0_req.arvalid = !ar_done;
            s_resp.rvalid  = ar_done;
            s_resp.rlast   = ar_done && (beats + 1 == rlast_beat);
            s_resp.rdata   = 32'hA500_0000 + beats;
            #1;
            if (grant == 2'b01) seen = 1'b1;
            else if (seen) fin = 1'b1;
            if (!fin) begin
                if (s_req.arvalid && s_resp.rready) ar_done = 1'b1;
                if (m0_resp.rvalid && m0_req.rready) begin
                    chk("rd_data", m0_resp.rdata, 32'hA500_0000 + beats);
                    beats++;
                end
                tick();
            end
        end
        if (!fin) begin
            n_vec++; n_err++;
            $display("FAIL read_txn_timeout: got no completion expected grant release");
        end
        m0_req.arvalid = 1'b0; s_resp.rvalid = 1'b0; s_resp.rlast = 1'b0;
    endtask

    logic [1:0] rr_exp [12] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10,
                                2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
    logic [1:0] fp_exp [12] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10,
                                2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01};

    initial begin
        int beats, mb, sb, bcnt, grant_bad;
        bit aw_done, b_done, seen;

        rst = 1'b1; m0_req = '0; m1_req = '0; fp_m1_req = '0; s_resp = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("reset_grant", grant, 2'b00);
        chk("reset_s_req_zero", 32'(s_req == '0), 1);
        chk("reset_proto_err", proto_err, 0);

        // Read of 4 beats by M0, tie won by M1 (last owner M0), then queued M0 read.
        tbl[0]  = mk(1,0,0,0,0, 2'b00, 0, 32'h0,         0,0,0);
        tbl[1]  = mk(1,0,1,0,0, 2'b01, 1, 32'h8000_0000, 0,0,0);
        tbl[2]  = mk(0,0,0,1,0, 2'b01, 0, 32'h0,         1,1,0);
        tbl[3]  = mk(0,0,0,0,0, 2'b01, 0, 32'h0,         1,0,0);
        tbl[4]  = mk(0,0,0,1,0, 2'b01, 0, 32'h0,         1,1,0);
        tbl[5]  = mk(0,0,0,1,0, 2'b01, 0, 32'h0,         1,1,0);
        tbl[6]  = mk(0,0,0,1,1, 2'b01, 0, 32'h0,         1,1,0);
        tbl[7]  = mk(0,0,0,0,0, 2'b00, 0, 32'h0,         0,0,0);
        tbl[8]  = mk(1,1,0,0,0, 2'b00, 0, 32'h0,         0,0,0);
        tbl[9]  = mk(1,1,1,0,0, 2'b10, 1, 32'h0000_1000, 0,0,0);
        tbl[10] = mk(1,0,0,1,0, 2'b10, 0, 32'h0,         1,0,1);
        tbl[11] = mk(1,0,0,1,1, 2'b10, 0, 32'h0,         1,0,1);
        tbl[12] = mk(1,0,0,0,0, 2'b00, 0, 32'h0,         0,0,0);
        tbl[13] = mk(1,0,0,0,0, 2'b01, 1, 32'h8000_0000, 0,0,0);
        tbl[14] = mk(1,0,1,0,0, 2'b01, 1, 32'h8000_0000, 0,0,0);
        tbl[15] = mk(0,0,0,1,0, 2'b01, 0, 32'h0,         1,1,0);
        tbl[16] = mk(0,0,0,1,0, 2'b01, 0, 32'h0,         1,1,0);
        tbl[17] = mk(0,0,0,1,0, 2'b01, 0, 32'h0,         1,1,0);
        tbl[18] = mk(0,0,0,1,1, 2'b01, 0, 32'h0,         1,1,0);
        tbl[19] = mk(0,0,0,0,0, 2'b00, 0, 32'h0,         0,0,0);

        m0_req.araddr = 32'h8000_0000; m0_req.rlen = 4'd4; m0_req.rready = 1'b1;
        m1_req.araddr = 32'h0000_1000; m1_req.rlen = 4'd2; m1_req.rready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            m0_req.arvalid = tbl[i].m0_ar;
            m1_req.arvalid = tbl[i].m1_ar;
            s_resp.rready  = tbl[i].s_arrdy;
            s_resp.rvalid  = tbl[i].s_rvalid;
            s_resp.rlast   = tbl[i].s_rlast;
            s_resp.rdata   = 32'hD000_0000 + i;
            #1;
            $display("vec %0d: grant=%b s_arvalid=%b m0_rvalid=%b m1_rvalid=%b",
                     i, grant, s_req.arvalid, m0_resp.rvalid, m1_resp.rvalid);
            chk($sformatf("tbl%0d_grant", i), grant, tbl[i].grant);
            chk($sformatf("tbl%0d_s_arvalid", i), s_req.arvalid, tbl[i].s_arvalid);
            chk($sformatf("tbl%0d_s_araddr", i), s_req.araddr, tbl[i].s_araddr);
            chk($sformatf("tbl%0d_s_rready", i), s_req.rready, tbl[i].s_rready);
            chk($sformatf("tbl%0d_m0_rvalid", i), m0_resp.rvalid, tbl[i].m0_rvalid);
            chk($sformatf("tbl%0d_m1_rvalid", i), m1_resp.rvalid, tbl[i].m1_rvalid);
            if (tbl[i].grant != 2'b01) chk($sformatf("tbl%0d_m0_resp_zero", i), 32'(m0_resp == '0), 1);
            if (tbl[i].grant != 2'b10) chk($sformatf("tbl%0d_m1_resp_zero", i), 32'(m1_resp == '0), 1);
            chk($sformatf("tbl%0d_proto_err", i), proto_err, 0);
            tick();
        end

        // Both masters request continuously: round-robin alternates, fixed priority favours M1.
        do_reset();
        m0_req = '0; m1_req = '0;
        m0_req.rlen = 4'd1; m0_req.rready = 1'b1; m0_req.arvalid = 1'b1; m0_req.araddr = 32'h100;
        m1_req.rlen = 4'd1; m1_req.rready = 1'b1; m1_req.arvalid = 1'b1; m1_req.araddr = 32'h200;
        s_resp = '0; s_resp.rready = 1'b1; s_resp.rvalid = 1'b1; s_resp.rlast = 1'b1;
        for (int c = 0; c < 12; c++) begin
            fp_m1_req = m1_req;
            fp_m1_req.arvalid = (c < 8);
            #1;
            $display("arb cycle %0d: rr_grant=%b fp_grant=%b", c, grant, fp_grant);
            chk($sformatf("rr_grant_c%0d", c), grant, rr_exp[c]);
            chk($sformatf("fp_grant_c%0d", c), fp_grant, fp_exp[c]);
            tick();
        end
        m0_req = '0; m1_req = '0; fp_m1_req = '0; s_resp = '0;
        do_reset();

        // M1 write-back of 8 beats, slave wready every other cycle, bvalid 3 cycles after wlast.
        aw_done = 1'b0; b_done = 1'b0; seen = 1'b0; mb = 0; sb = 0; bcnt = -1; grant_bad = 0;
        m1_req.waddr = 32'h0000_2000; m1_req.wlen = 4'd8; m1_req.wstrb = 4'hF; m1_req.bready = 1'b1;
        for (int c = 0; c < 100 && !b_done; c++) begin
            m1_req.awvalid = !aw_done;
            m1_req.wvalid  = (mb < 8);
            m1_req.wdata   = 32'hC0DE_0000 + mb;
            m1_req.wlast   = (mb == 7);
            s_resp.awready = 1'b1;
            s_resp.wready  = c[0];
            s_resp.bvalid  = (bcnt == 0);
            #1;
            if (grant == 2'b10) seen = 1'b1;
            else if (seen) grant_bad++;
            if (s_req.awvalid) chk("wr_w_masked_in_aw", s_req.wvalid, 0);
            if (s_req.awvalid && s_resp.awready) aw_done = 1'b1;
            if (bcnt > 0) bcnt--;
            if (s_req.wvalid && s_resp.wready) begin
                chk("wr_data", s_req.wdata, 32'hC0DE_0000 + sb);
                chk("wr_strb", s_req.wstrb, 4'hF);
                sb++;
                if (s_req.wlast) bcnt = 2;
            end
            if (m1_resp.wready && m1_req.wvalid) mb++;
            if (s_resp.bvalid && s_req.bready) begin
                b_done = 1'b1;
                bcnt = -1;
            end
            tick();
        end
        m1_req = '0; s_resp = '0;
        #1;
        $display("write: slave_beats=%0d b_done=%0d grant=%b", sb, b_done, grant);
        chk("wr_b_done", b_done, 1);
        chk("wr_slave_beats", sb, 8);
        chk("wr_grant_held", grant_bad, 0);
        chk("wr_idle_after_b", grant, 2'b00);
        chk("wr_proto_err", proto_err, 0);
        tick();

        // Early rlast: error flagged, and stays through a later clean burst.
        read_txn(4'd4, 3, beats);
        $display("short read: beats=%0d proto_err=%b", beats, proto_err);
        chk("short_rd_beats", beats, 3);
        chk("short_rd_proto_err", proto_err, 1);
        chk("short_rd_idle", grant, 2'b00);
        tick();
        read_txn(4'd4, 4, beats);
        $display("clean read: beats=%0d proto_err=%b", beats, proto_err);
        chk("clean_rd_beats", beats, 4);
        chk("sticky_proto_err", proto_err, 1);
        tick();

        // Reset during beat 2 of a 16-beat read.
        m0_req.araddr = 32'h8000_0200; m0_req.rlen = 4'd0; m0_req.rready = 1'b1; m0_req.arvalid = 1'b1;
        s_resp.rready = 1'b1;
        #1; chk("rst16_idle", grant, 2'b00); tick();
        #1; chk("rst16_ar", s_req.arvalid, 1); tick();
        m0_req.arvalid = 1'b0; s_resp.rvalid = 1'b1;
        #1; chk("rst16_beat1", m0_resp.rvalid, 1); tick();
        rst = 1'b1;
        #1; chk("rst16_midburst_grant", grant, 2'b01); tick();
        rst = 1'b0; s_resp.rvalid = 1'b0;
        #1;
        $display("after reset: grant=%b s_req_zero=%b proto_err=%b", grant, s_req == '0, proto_err);
        chk("rst16_grant", grant, 2'b00);
        chk("rst16_s_req_zero", 32'(s_req == '0), 1);
        chk("rst16_m0_resp_zero", 32'(m0_resp == '0), 1);
        chk("rst16_m1_resp_zero", 32'(m1_resp == '0), 1);
        chk("rst16_proto_err", proto_err, 0);
        tick();
        read_txn(4'd4, 4, beats);
        chk("rerequest_beats", beats, 4);
        chk("rerequest_proto_err", proto_err, 0);
        tick();

        // Final expected beat without rlast also ends the burst with an error.
        read_txn(4'd2, 99, beats);
        $display("missing rlast: beats=%0d proto_err=%b", beats, proto_err);
        chk("no_rlast_beats", beats, 2);
        chk("no_rlast_proto_err", proto_err, 1);
        chk("no_rlast_idle", grant, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
